// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes and FSM states.
package mul_div_unit_pkg;

  localparam logic [1:0] MULT_OP  = 2'b00;
  localparam logic [1:0] MULTU_OP = 2'b01;
  localparam logic [1:0] DIV_OP   = 2'b10;
  localparam logic [1:0] DIVU_OP  = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2
  } state_e;

  // MULT and DIV treat their operands as two's complement; the U variants do not.
  function automatic logic is_signed_op(logic [1:0] op);
    return !op[0];
  endfunction

endpackage

// File: rtl/mul_div_unit_div_core.sv
// Restoring-division step datapath: one quotient bit per enabled cycle.
module mul_div_unit_div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  logic [WIDTH-1:0] rem_q, rem_d;
  // Holds the unconsumed dividend bits at the top and shifts quotient bits in at the bottom.
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, divisor_i};
    if (load_i) begin
      rem_d = '0;
      quo_d = dividend_i;
    end else if (step_i) begin
      // diff[WIDTH] set means the subtraction went negative: restore.
      quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
      rem_d = diff[WIDTH] ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
    end
  end

  // Partial remainder and quotient registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q <= '0;
      quo_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with start/busy/done handshake and cancel.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_mag_q, a_mag_d;
  logic [WIDTH-1:0]   b_mag_q, b_mag_d;
  logic [WIDTH-1:0]   a_orig_q, a_orig_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               b_zero_q, b_zero_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;
  logic               done_q, done_d;

  logic               div_load, div_step;
  logic [WIDTH-1:0]   div_quo, div_rem;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic               fix_dbz;

  mul_div_unit_div_core #(
    .WIDTH (WIDTH)
  ) u_div_core (
    .clk_i       (clk),
    .rst_ni      (resetn),
    .load_i      (div_load),
    .step_i      (div_step),
    .dividend_i  (a_mag_d),
    .divisor_i   (b_mag_q),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  // Shift-add multiply step: acc holds {partial product, unconsumed multiplier bits}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  end

  // Sign correction and divide-by-zero result selection applied when leaving FIX.
  always_comb begin
    prod    = acc_q;
    fix_hi  = '0;
    fix_lo  = '0;
    fix_dbz = 1'b0;
    if (!op_q[1]) begin
      if ((op_q == MULT_OP) && (sign_a_q ^ sign_b_q)) begin
        prod = -acc_q;
      end
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end else if (b_zero_q) begin
      fix_hi  = a_orig_q;
      fix_lo  = '1;
      fix_dbz = 1'b1;
    end else begin
      // Sign flags are only ever set for DIV, so DIVU passes through unchanged.
      fix_lo = (sign_a_q ^ sign_b_q) ? -div_quo : div_quo;
      fix_hi = sign_a_q ? -div_rem : div_rem;
    end
  end

  // Next-state logic for the IDLE -> CALC -> FIX sequencer and operand capture.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    a_orig_d = a_orig_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    b_zero_d = b_zero_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;
    div_load = 1'b0;
    div_step = 1'b0;
    case (state_q)
      StIdle: begin
        if (start && !cancel) begin
          op_d     = op;
          sign_a_d = is_signed_op(op) & a[WIDTH-1];
          sign_b_d = is_signed_op(op) & b[WIDTH-1];
          a_mag_d  = sign_a_d ? -a : a;
          b_mag_d  = sign_b_d ? -b : b;
          a_orig_d = a;
          b_zero_d = (b == '0);
          cnt_d    = CntW'(WIDTH);
          acc_d    = {{WIDTH{1'b0}}, b_mag_d};
          div_load = 1'b1;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        if (cancel) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
          if (op_q[1]) begin
            div_step = 1'b1;
          end else begin
            acc_d = mul_next;
          end
          if (cnt_q == CntW'(1)) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!cancel) begin
          hi_d   = fix_hi;
          lo_d   = fix_lo;
          dbz_d  = fix_dbz;
          done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      a_orig_q <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      a_orig_q <= a_orig_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      b_zero_q <= b_zero_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (WIDTH=32).
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cancel;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mul_div_unit #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .cancel      (cancel),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request and let the next rising edge sample it; returns 1 ns after that edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges from the sampling edge (edge 1) until done is seen; busy must stay high before.
  task automatic wait_done(output int edges, output logic busy_gap);
    edges    = 1;
    busy_gap = 1'b0;
    while (!done && edges < 200) begin
      if (!busy) busy_gap = 1'b1;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic run_check(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [W-1:0] exp_hi,
                           input logic [W-1:0] exp_lo, input logic exp_dbz);
    int   edges;
    logic gap;
    issue(o, x, y);
    wait_done(edges, gap);
    chk({tag, "_latency"}, 64'(edges), 64'd34);
    chk({tag, "_busy_gap"}, 64'(gap), 64'd0);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
  endtask

  initial begin
    logic saw_done;
    resetn = 1'b0;
    start  = 1'b0;
    cancel = 1'b0;
    op     = 2'b00;
    a      = '0;
    b      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // MULT -2 * 3, then done must drop after one cycle with results held.
    run_check("mult_neg", MULT_OP, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF,
              32'hFFFF_FFFA, 1'b0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("hold_lo", 64'(lo), 64'h0000_0000_FFFF_FFFA);

    // MULTU max*max, then MULT issued in the done cycle.
    run_check("multu_max", MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
              32'h0000_0001, 1'b0);
    run_check("mult_b2b", MULT_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000,
              32'h0000_0001, 1'b0);

    // Signed and unsigned divide of the same bit patterns.
    run_check("div_neg", DIV_OP, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF,
              32'hFFFF_FFFD, 1'b0);
    run_check("divu", DIVU_OP, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001,
              32'h7FFF_FFFC, 1'b0);

    // Signed overflow.
    run_check("div_ovf", DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000,
              32'h8000_0000, 1'b0);

    // Divide by zero, then a multiply clears the flag.
    run_check("divu_zero", DIVU_OP, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234,
              32'hFFFF_FFFF, 1'b1);
    run_check("multu_small", MULTU_OP, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000,
              32'h0000_0006, 1'b0);

    // DIV 100/7 with an ignored start at edge 5 and a cancel at edge 10.
    issue(DIV_OP, 32'd100, 32'd7);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    op    = MULTU_OP;
    a     = 32'd5;
    b     = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ignored_start_busy", 64'(busy), 64'd1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    chk("cancel_busy", 64'(busy), 64'd0);
    chk("cancel_done", 64'(done), 64'd0);
    chk("cancel_hi", 64'(hi), 64'd0);
    chk("cancel_lo", 64'(lo), 64'd6);
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("cancel_no_done", 64'(saw_done), 64'd0);
    chk("cancel_lo_held", 64'(lo), 64'd6);

    // Cancel and start together in IDLE: cancel wins.
    cancel = 1'b1;
    issue(DIV_OP, 32'd100, 32'd7);
    cancel = 1'b0;
    chk("cancel_start_idle", 64'(busy), 64'd0);

    run_check("div_restart", DIV_OP, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 1'b0);

    // Asynchronous reset mid-CALC clears outputs without a clock edge.
    issue(DIV_OP, 32'd100, 32'd7);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    #2;
    resetn = 1'b0;
    #1;
    chk("areset_busy", 64'(busy), 64'd0);
    chk("areset_done", 64'(done), 64'd0);
    chk("areset_hi", 64'(hi), 64'd0);
    chk("areset_lo", 64'(lo), 64'd0);
    chk("areset_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
